// File: rtl/toe_conn_ctrl_if.sv
// Request/response channel between the connection controller and the
// connection-table searcher.
interface toe_conn_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_ip_src;
    logic [31:0] req_ip_dst;
    logic [47:0] req_mac_src;
    logic [47:0] req_mac_dst;
    logic [15:0] req_port_src;
    logic [15:0] req_port_dst;
    logic [7:0]  req_id;
    logic        rsp_valid;
    logic [7:0]  rsp_error;
    logic [7:0]  rsp_id;

    // A request transfers on a cycle where req_valid and req_ready are both high;
    // req_* stay stable while req_valid is high. rsp_valid is a 1-cycle pulse, never stalled.
    modport master (
        output req_valid, req_op, req_ip_src, req_ip_dst, req_mac_src, req_mac_dst,
               req_port_src, req_port_dst, req_id,
        input  req_ready, rsp_valid, rsp_error, rsp_id
    );

    modport slave (
        input  req_valid, req_op, req_ip_src, req_ip_dst, req_mac_src, req_mac_dst,
               req_port_src, req_port_dst, req_id,
        output req_ready, rsp_valid, rsp_error, rsp_id
    );
endinterface

// File: rtl/toe_conn_ctrl.sv
// Avalon-MM front-end that queues TCP open/close commands and issues them one
// at a time to the connection-table searcher, reporting each completion.
module toe_conn_ctrl #(
    parameter int               DEPTH       = 4,
    parameter int               TMO_W       = 16,
    parameter logic [TMO_W-1:0] TMO_DEFAULT = 16'd1000,
    parameter logic [7:0]       ERR_TIMEOUT = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      address,
    input  logic            chipselect,
    input  logic            write,
    input  logic [31:0]     writedata,
    input  logic            read,
    output logic [31:0]     readdata,
    output logic            irq,
    output logic [1:0]      dbg_state,
    toe_conn_ctrl_if.master srch
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CPL   = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] ip_src;
        logic [31:0] ip_dst;
        logic [47:0] mac_src;
        logic [47:0] mac_dst;
        logic [15:0] port_src;
        logic [15:0] port_dst;
        logic [7:0]  id;
    } cmd_t;

    state_t           state;
    logic [31:0]      ip_src_r, ip_dst_r;
    logic [47:0]      mac_src_r, mac_dst_r;
    logic [15:0]      port_src_r, port_dst_r;
    logic [7:0]       id_r;
    logic [TMO_W-1:0] timeout_r;
    logic [1:0]       irq_en;
    logic             overflow;

    cmd_t             fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full, fifo_empty;

    logic [TMO_W-1:0] timer;
    logic             tmo_en;
    logic [7:0]       hold_err, hold_id;
    logic             cpl_valid;
    logic [7:0]       res_err, res_id;
    logic [1:0]       res_op;

    logic             wr_en, rd_en, push_req, push_ok, pop, cpl_pop, ovf_clr;
    cmd_t             stage_c, head;
    logic [31:0]      rd_mux;

    assign wr_en      = chipselect & write;
    assign rd_en      = chipselect & read;
    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = wr_en && (address == 4'h0) &&
                        (writedata[1:0] == 2'b01 || writedata[1:0] == 2'b10);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a push on the cycle its head is popped.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign cpl_pop    = wr_en && (address == 4'h1) && writedata[0];
    assign ovf_clr    = wr_en && (address == 4'h1) && writedata[3];
    assign head       = fifo_mem[rd_ptr];
    assign dbg_state  = state;

    assign stage_c = '{op: writedata[1:0], ip_src: ip_src_r, ip_dst: ip_dst_r,
                       mac_src: mac_src_r, mac_dst: mac_dst_r,
                       port_src: port_src_r, port_dst: port_dst_r, id: id_r};

    // Staging and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_src_r   <= '0;
            ip_dst_r   <= '0;
            mac_src_r  <= '0;
            mac_dst_r  <= '0;
            port_src_r <= '0;
            port_dst_r <= '0;
            id_r       <= '0;
            timeout_r  <= TMO_DEFAULT;
            irq_en     <= '0;
        end else if (wr_en) begin
            case (address)
                4'h3: ip_src_r          <= writedata;
                4'h4: ip_dst_r          <= writedata;
                4'h5: mac_src_r[31:0]   <= writedata;
                4'h6: mac_src_r[47:32]  <= writedata[15:0];
                4'h7: mac_dst_r[31:0]   <= writedata;
                4'h8: mac_dst_r[47:32]  <= writedata[15:0];
                4'h9: begin
                    port_src_r <= writedata[15:0];
                    port_dst_r <= writedata[31:16];
                end
                4'hA: id_r      <= writedata[7:0];
                4'hB: timeout_r <= writedata[TMO_W-1:0];
                4'hC: irq_en    <= writedata[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= stage_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (ovf_clr)         overflow <= 1'b0;
        end
    end

    // Request sequencer and completion slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            srch.req_valid    <= 1'b0;
            srch.req_op       <= '0;
            srch.req_ip_src   <= '0;
            srch.req_ip_dst   <= '0;
            srch.req_mac_src  <= '0;
            srch.req_mac_dst  <= '0;
            srch.req_port_src <= '0;
            srch.req_port_dst <= '0;
            srch.req_id       <= '0;
            timer             <= '0;
            tmo_en            <= 1'b0;
            hold_err          <= '0;
            hold_id           <= '0;
            cpl_valid         <= 1'b0;
            res_err           <= '0;
            res_id            <= '0;
            res_op            <= '0;
        end else begin
            if (cpl_pop) cpl_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        srch.req_op       <= head.op;
                        srch.req_ip_src   <= head.ip_src;
                        srch.req_ip_dst   <= head.ip_dst;
                        srch.req_mac_src  <= head.mac_src;
                        srch.req_mac_dst  <= head.mac_dst;
                        srch.req_port_src <= head.port_src;
                        srch.req_port_dst <= head.port_dst;
                        srch.req_id       <= head.id;
                        timer             <= timeout_r;
                        tmo_en            <= (timeout_r != '0);
                        srch.req_valid    <= 1'b1;
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (srch.req_ready) begin
                        srch.req_valid <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    timer <= timer - 1'b1;
                    // A response arriving on the expiry cycle takes priority.
                    if (srch.rsp_valid) begin
                        hold_err <= srch.rsp_error;
                        hold_id  <= srch.rsp_id;
                        state    <= S_CPL;
                    end else if (tmo_en && timer == TMO_W'(1)) begin
                        hold_err <= ERR_TIMEOUT;
                        hold_id  <= srch.req_id;
                        state    <= S_CPL;
                    end
                end
                S_CPL: begin
                    if (!cpl_valid || cpl_pop) begin
                        res_err   <= hold_err;
                        res_id    <= hold_id;
                        res_op    <= srch.req_op;
                        cpl_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            4'h1: rd_mux = {19'b0, 5'(count), 3'b0, (state != S_IDLE), overflow,
                            fifo_empty, fifo_full, cpl_valid};
            4'h2: rd_mux = {14'b0, res_op, res_id, res_err};
            4'h3: rd_mux = ip_src_r;
            4'h4: rd_mux = ip_dst_r;
            4'h5: rd_mux = mac_src_r[31:0];
            4'h6: rd_mux = {16'b0, mac_src_r[47:32]};
            4'h7: rd_mux = mac_dst_r[31:0];
            4'h8: rd_mux = {16'b0, mac_dst_r[47:32]};
            4'h9: rd_mux = {port_dst_r, port_src_r};
            4'hA: rd_mux = {24'b0, id_r};
            4'hB: rd_mux = 32'(timeout_r);
            4'hC: rd_mux = {30'b0, irq_en};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (rd_en) readdata <= rd_mux;
            irq <= (irq_en[0] & cpl_valid) | (irq_en[1] & overflow);
        end
    end
endmodule

// File: tb/tb_toe_conn_ctrl.sv
// Self-checking bench for toe_conn_ctrl: directed scenarios plus randomized
// tuples, checked against a queue-based model of the command/completion flow.
module tb_toe_conn_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  address;
  logic        chipselect, write, read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [1:0]  dbg_state;

  toe_conn_ctrl_if srch();

  toe_conn_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .address    (address),
    .chipselect (chipselect),
    .write      (write),
    .writedata  (writedata),
    .read       (read),
    .readdata   (readdata),
    .irq        (irq),
    .dbg_state  (dbg_state),
    .srch       (srch)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [47:0] mac_src;
    logic [47:0] mac_dst;
    logic [15:0] ps;
    logic [15:0] pd;
    logic [7:0]  id;
  } req_t;

  // Reference model: queued commands, the one in flight, the completion slot
  // and a completion waiting behind a full slot.
  req_t        m_q[$];
  req_t        stg, cur;
  bit          busy, slot_v, pend_v, m_ovf;
  logic [17:0] slot_res, pend_res;

  int tests = 0;
  int fails = 0;
  int cyc, d;
  logic [31:0] rd;
  logic [7:0]  e_err, e_id;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    busy = 0; slot_v = 0; pend_v = 0; m_ovf = 0;
  endtask

  task automatic m_take();
    if (!busy && m_q.size() > 0) begin
      cur  = m_q.pop_front();
      busy = 1;
    end
  endtask

  task automatic m_push(input logic [1:0] op);
    req_t e;
    e = stg;
    e.op = op;
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else m_ovf = 1;
    m_take();
  endtask

  task automatic m_complete(input logic [7:0] err, input logic [7:0] id);
    if (!slot_v) begin
      slot_v = 1; slot_res = {cur.op, id, err}; busy = 0;
      m_take();
    end else begin
      pend_v = 1; pend_res = {cur.op, id, err};
    end
  endtask

  task automatic m_pop();
    slot_v = 0;
    if (pend_v) begin
      slot_v = 1; slot_res = pend_res; pend_v = 0; busy = 0;
      m_take();
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {19'b0, 5'(m_q.size()), 3'b0, busy, m_ovf, (m_q.size() == 0),
            (m_q.size() == DEPTH), slot_v};
  endfunction

  function automatic logic [255:0] req_vec(input req_t r);
    return 256'({r.op, r.ip_src, r.ip_dst, r.mac_src, r.mac_dst, r.ps, r.pd, r.id});
  endfunction

  function automatic logic [255:0] dut_vec();
    return 256'({srch.req_op, srch.req_ip_src, srch.req_ip_dst, srch.req_mac_src,
                 srch.req_mac_dst, srch.req_port_src, srch.req_port_dst, srch.req_id});
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic av_wr(input logic [3:0] a, input logic [31:0] wd);
    chipselect = 1; write = 1; address = a; writedata = wd;
    @(negedge clk);
    chipselect = 0; write = 0;
  endtask

  task automatic av_rd(input logic [3:0] a, output logic [31:0] data);
    chipselect = 1; read = 1; address = a;
    @(negedge clk);
    data = readdata;
    chipselect = 0; read = 0;
  endtask

  task automatic rand_stage();
    stg.ip_src  = $urandom();
    stg.ip_dst  = $urandom();
    stg.mac_src = 48'({$urandom(), $urandom()});
    stg.mac_dst = 48'({$urandom(), $urandom()});
    stg.ps      = 16'($urandom_range(0, 65535));
    stg.pd      = 16'($urandom_range(0, 65535));
    stg.id      = 8'($urandom_range(0, 255));
  endtask

  task automatic write_stage();
    av_wr(4'h3, stg.ip_src);
    av_wr(4'h4, stg.ip_dst);
    av_wr(4'h5, stg.mac_src[31:0]);
    av_wr(4'h6, {16'b0, stg.mac_src[47:32]});
    av_wr(4'h7, stg.mac_dst[31:0]);
    av_wr(4'h8, {16'b0, stg.mac_dst[47:32]});
    av_wr(4'h9, {stg.pd, stg.ps});
    av_wr(4'hA, {24'b0, stg.id});
  endtask

  task automatic push(input logic [1:0] op);
    av_wr(4'h0, {30'b0, op});
    if (op == 2'b01 || op == 2'b10) m_push(op);
  endtask

  task automatic wait_req(input string tag);
    cyc = 0;
    while (!srch.req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_req_valid"}, 256'(srch.req_valid), 256'(1));
    check({tag, "_req_fields"}, dut_vec(), req_vec(cur));
  endtask

  task automatic accept();
    srch.req_ready = 1;
    @(negedge clk);
    srch.req_ready = 0;
    check("req_valid_drop", 256'(srch.req_valid), 256'(0));
  endtask

  task automatic respond(input logic [7:0] err, input logic [7:0] id);
    srch.rsp_valid = 1; srch.rsp_error = err; srch.rsp_id = id;
    @(negedge clk);
    srch.rsp_valid = 0; srch.rsp_error = 0; srch.rsp_id = 0;
    m_complete(err, id);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    av_rd(4'h1, rd);
    check(tag, 256'(rd), 256'(exp_status()));
  endtask

  task automatic check_result(input string tag);
    av_rd(4'h2, rd);
    check(tag, 256'(rd), 256'({14'b0, slot_res}));
  endtask

  task automatic pop_cpl();
    av_wr(4'h1, 32'h1);
    m_pop();
  endtask

  initial begin
    rst_n = 0; address = 0; chipselect = 0; write = 0; writedata = 0; read = 0;
    srch.req_ready = 0; srch.rsp_valid = 0; srch.rsp_error = 0; srch.rsp_id = 0;
    m_reset();
    stg = '{default: '0};
    repeat (3) @(negedge clk);
    check("rst_readdata", 256'(readdata), 256'(0));
    check("rst_irq", 256'(irq), 256'(0));
    check("rst_req_valid", 256'(srch.req_valid), 256'(0));
    check("rst_req_bus", dut_vec(), 256'(0));
    rst_n = 1;
    @(negedge clk);
    check_status("rst_status");
    av_rd(4'hB, rd);
    check("rst_timeout", 256'(rd), 256'(1000));

    // Directed open with known fields
    rand_stage();
    stg.ip_src = 32'h0A00_0001; stg.mac_src = 48'h1122_3344_5566;
    stg.ps = 16'h1F90; stg.pd = 16'h0050;
    write_stage();
    av_rd(4'h9, rd);
    check("ports_readback", 256'(rd), 256'(32'h0050_1F90));
    av_rd(4'h6, rd);
    check("mac_hi_readback", 256'(rd), 256'(32'h0000_1122));
    push(2'b01);
    wait_req("t1");
    check("t1_latency", 256'(cyc <= 2), 256'(1));
    accept();
    repeat (2) @(negedge clk);
    respond(8'h00, 8'h05);
    check_status("t1_status");
    check_result("t1_result");
    check("t1_result_abs", 256'(rd), 256'(32'h0001_0500));
    pop_cpl();
    check_status("t1_status_popped");

    // Randomized tuples, delays, ignored opcodes and stray responses
    for (int i = 0; i < 8; i++) begin
      rand_stage();
      write_stage();
      if ($urandom_range(0, 1) == 1) push($urandom_range(0, 1) == 1 ? 2'b11 : 2'b00);
      push(2'($urandom_range(1, 2)));
      wait_req("rnd");
      if ($urandom_range(0, 1) == 1) begin
        srch.rsp_valid = 1; srch.rsp_id = 8'hEE;
        @(negedge clk);
        srch.rsp_valid = 0; srch.rsp_id = 0;
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      check("rnd_req_stable", dut_vec(), req_vec(cur));
      accept();
      d = $urandom_range(0, 5);
      repeat (d) @(negedge clk);
      e_err = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(1, 254));
      e_id  = 8'($urandom_range(0, 255));
      respond(e_err, e_id);
      check_status("rnd_status");
      check_result("rnd_result");
      pop_cpl();
    end

    // Fill, overflow, clear, then drain in order
    for (int i = 0; i < 4; i++) begin
      rand_stage(); write_stage(); push(2'b01);
    end
    check_status("fill4_status");
    rand_stage(); write_stage(); push(2'b10);
    check_status("fill5_status");
    av_wr(4'hC, 32'h2);
    rand_stage(); write_stage(); push(2'b01);
    check_status("ovf_status");
    @(negedge clk);
    check("ovf_irq", 256'(irq), 256'(1));
    av_wr(4'h1, 32'h8);
    m_ovf = 0;
    check_status("ovf_clear_status");
    check("ovf_irq_clear", 256'(irq), 256'(0));
    av_wr(4'hC, 32'h0);
    for (int i = 0; i < 5; i++) begin
      wait_req("drain");
      accept();
      e_id = 8'($urandom_range(0, 255));
      respond(8'h00, e_id);
      check_result("drain_result");
      pop_cpl();
    end
    check_status("drain_status");

    // Completion back-pressure holds the sequencer in CPL
    for (int i = 0; i < 3; i++) begin
      rand_stage(); write_stage(); push(2'($urandom_range(1, 2)));
    end
    wait_req("bp_a"); accept(); respond(8'h11, 8'hA1);
    wait_req("bp_b"); accept(); respond(8'h22, 8'hB2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_held", 256'(srch.req_valid), 256'(0));
    end
    check_status("bp_status");
    check_result("bp_result_a");
    pop_cpl();
    check_result("bp_result_b");
    pop_cpl();
    wait_req("bp_c"); accept(); respond(8'h00, 8'hC3);
    check_result("bp_result_c");
    pop_cpl();

    // Timeout after exactly TIMEOUT wait cycles
    av_wr(4'hB, 32'd10);
    av_rd(4'hB, rd);
    check("tmo_readback", 256'(rd), 256'(10));
    rand_stage(); write_stage(); push(2'b10);
    wait_req("tmo");
    accept();
    repeat (10) @(negedge clk);
    check_status("tmo_not_yet");
    m_complete(8'hFF, cur.id);
    check_status("tmo_done");
    check_result("tmo_result");
    pop_cpl();
    av_wr(4'hB, 32'd1000);

    // Completion interrupt and ignored opcodes
    av_wr(4'hC, 32'h1);
    rand_stage(); write_stage(); push(2'b01);
    wait_req("irq"); accept(); respond(8'h00, 8'h42);
    check("irq_set", 256'(irq), 256'(1));
    pop_cpl();
    @(negedge clk);
    check("irq_clear", 256'(irq), 256'(0));
    push(2'b00);
    push(2'b11);
    check_status("noop_status");

    // Reset while waiting on the searcher
    rand_stage(); write_stage(); push(2'b01);
    wait_req("rst_a"); accept(); respond(8'h00, 8'h07);
    check_result("rst_a_result");
    push(2'b10);
    wait_req("rst_b"); accept();
    repeat (2) @(negedge clk);
    check("pre_rst_irq", 256'(irq), 256'(1));
    rst_n = 0;
    #1;
    check("mid_rst_req_valid", 256'(srch.req_valid), 256'(0));
    check("mid_rst_irq", 256'(irq), 256'(0));
    check("mid_rst_readdata", 256'(readdata), 256'(0));
    check("mid_rst_req_bus", dut_vec(), 256'(0));
    @(negedge clk);
    rst_n = 1;
    m_reset();
    @(negedge clk);
    check_status("post_rst_status");
    check("post_rst_status_abs", 256'(rd), 256'(32'h4));
    av_rd(4'hC, rd);
    check("post_rst_irq_en", 256'(rd), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
